// File: rtl/out_wrapper_buf.sv
// Output FIFO plus 4-phase outReady/outAccepted drain FSM behind the FP core.
// Optional OUT_DROP_FLAG_EN adds a sticky 'dropped' overflow flag.
module out_wrapper_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             doneFP,
    input  logic [WIDTH-1:0] result,
    input  logic             outAccepted,
    output logic [WIDTH-1:0] outBus,
    output logic             outReady,
    output logic             fpBusy,
`ifdef OUT_DROP_FLAG_EN
    output logic             dropped,
`endif
    output logic [PTR_W:0]   count
);

    typedef enum logic [1:0] {IDLE, PRESENT, RELEASE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             full, push, pop, load;

    assign full   = (count == (PTR_W+1)'(DEPTH));
    assign fpBusy = full;
    assign pop    = (state == PRESENT) && outAccepted;
    // A pop on the same edge frees the slot, so a push while full is still taken.
    assign push   = doneFP && (!full || pop);
    assign load   = (state == IDLE) && (count != '0);

    always_comb begin
        state_nxt = state;
        outReady  = 1'b0;
        case (state)
            IDLE:    if (count != '0) state_nxt = PRESENT;
            PRESENT: begin
                outReady = 1'b1;
                if (outAccepted) state_nxt = RELEASE;
            end
            RELEASE: if (!outAccepted) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            outBus <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            if (load) outBus <= mem[rd_ptr];
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= result;
    end

`ifdef OUT_DROP_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         dropped <= 1'b0;
        else if (doneFP && full && !pop) dropped <= 1'b1;
    end
`endif

endmodule
